// File: rtl/ahb_arb8.sv
// 8-master AHB-Lite arbiter: one-hot address-phase grant, one-hot data-phase select,
// round-robin with burst/lock hold and idle parking. Define AHB_ARB_FIXED_PRIO_EN for fixed priority.
module ahb_arb8 #(
  parameter logic [2:0]  DEF_MST = 3'd0,
  parameter int unsigned CNT_W   = 4
) (
  input  logic       hclk,
  input  logic       hrst,
  input  logic [7:0] mreq,
  input  logic [7:0] mlock,
  input  logic [1:0] htrans,
  input  logic [2:0] hburst,
  input  logic       hready,
  output logic [7:0] hgrant,
  output logic [7:0] dsel,
  output logic [2:0] hmaster,
  output logic       hmastlock
);

  localparam logic [1:0] HT_BUSY   = 2'b01;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ    = 2'b11;

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_BURST = 2'd1,
    ST_LOCK  = 2'd2
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       hgrant_q;
  logic [7:0]       dsel_q;
  logic [2:0]       hmaster_q;

  logic [2:0]       search_base;
  logic [7:0]       rot_req;
  logic [2:0]       win_idx;
  logic             burst_fixed;
  logic [CNT_W-1:0] burst_load;
  logic             lock_cur;
  logic             arb_pt;

`ifdef AHB_ARB_FIXED_PRIO_EN
  // Searching from 7+1 wraps to master 0 first, giving fixed 0..7 priority.
  assign search_base = 3'd7;
`else
  // rr_q tracks the current owner (parking included), so the search starts just past it.
  logic [2:0] rr_q;
  assign search_base = rr_q;
`endif

  // Request vector rotated so bit 0 is the first candidate in search order.
  for (genvar gi = 0; gi < 8; gi++) begin : g_rot
    assign rot_req[gi] = mreq[search_base + 3'(gi + 1)];
  end

  always_comb begin
    win_idx = DEF_MST;
    for (int k = 7; k >= 0; k--) begin
      if (rot_req[k]) begin
        win_idx = search_base + 3'(k + 1);
      end
    end
  end

  always_comb begin
    burst_fixed = 1'b1;
    burst_load  = '0;
    case (hburst)
      3'd2, 3'd3: burst_load = CNT_W'(3);
      3'd4, 3'd5: burst_load = CNT_W'(7);
      3'd6, 3'd7: burst_load = CNT_W'(15);
      default:    burst_fixed = 1'b0;
    endcase
  end

  assign lock_cur = mlock[hmaster_q];

  // A fixed burst re-arbitrates on the edge that accepts its last beat.
  always_comb begin
    arb_pt = 1'b0;
    if (hready && !lock_cur) begin
      case (state_q)
        ST_ARB:   arb_pt = !(htrans == HT_NONSEQ && burst_fixed);
        ST_BURST: arb_pt = (htrans == HT_SEQ) ? (cnt_q <= CNT_W'(1)) : (htrans != HT_BUSY);
        ST_LOCK:  arb_pt = (htrans != HT_SEQ);
        default:  arb_pt = 1'b1;
      endcase
    end
  end

  always_ff @(posedge hclk) begin
    if (hrst) begin
      state_q   <= ST_ARB;
      cnt_q     <= '0;
      hgrant_q  <= 8'b1 << DEF_MST;
      dsel_q    <= 8'b1 << DEF_MST;
      hmaster_q <= DEF_MST;
`ifndef AHB_ARB_FIXED_PRIO_EN
      rr_q      <= DEF_MST;
`endif
    end else if (hready) begin
      dsel_q <= hgrant_q;
      if (arb_pt) begin
        hgrant_q  <= 8'b1 << win_idx;
        hmaster_q <= win_idx;
`ifndef AHB_ARB_FIXED_PRIO_EN
        rr_q      <= win_idx;
`endif
      end
      if (lock_cur) begin
        state_q <= ST_LOCK;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          ST_ARB: begin
            if (htrans == HT_NONSEQ && burst_fixed) begin
              cnt_q   <= burst_load;
              state_q <= ST_BURST;
            end
          end
          ST_BURST: begin
            if (htrans == HT_SEQ) begin
              if (cnt_q <= CNT_W'(1)) begin
                cnt_q   <= '0;
                state_q <= ST_ARB;
              end else begin
                cnt_q <= cnt_q - CNT_W'(1);
              end
            end else if (htrans != HT_BUSY) begin
              cnt_q   <= '0;
              state_q <= ST_ARB;
            end
          end
          ST_LOCK: begin
            if (htrans != HT_SEQ) begin
              state_q <= ST_ARB;
            end
          end
          default: begin
            cnt_q   <= '0;
            state_q <= ST_ARB;
          end
        endcase
      end
    end
  end

  assign hgrant    = hgrant_q;
  assign dsel      = dsel_q;
  assign hmaster   = hmaster_q;
  assign hmastlock = |(hgrant_q & mlock);

endmodule

// File: tb/tb_ahb_arb8.sv
// Directed scoreboard bench for ahb_arb8: stimulus pushes the expected per-cycle outputs,
// a negedge monitor pops and compares them.
module tb_ahb_arb8;

  logic       hclk = 1'b0;
  logic       hrst;
  logic [7:0] mreq;
  logic [7:0] mlock;
  logic [1:0] htrans;
  logic [2:0] hburst;
  logic       hready;
  logic [7:0] hgrant;
  logic [7:0] dsel;
  logic [2:0] hmaster;
  logic       hmastlock;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] NSEQ = 2'd2;
  localparam logic [1:0] SEQ  = 2'd3;
  localparam logic [2:0] SINGLE = 3'd0;
  localparam logic [2:0] INCR4  = 3'd3;
  localparam logic [2:0] INCR8  = 3'd5;
  localparam logic [2:0] WRAP16 = 3'd6;

  typedef struct {
    logic [7:0] g;
    logic [7:0] d;
    logic [2:0] m;
    logic       l;
    string      tag;
  } exp_t;

  exp_t sb_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 hclk = ~hclk;

  ahb_arb8 #(.DEF_MST(3'd0), .CNT_W(4)) dut (
    .hclk      (hclk),
    .hrst      (hrst),
    .mreq      (mreq),
    .mlock     (mlock),
    .htrans    (htrans),
    .hburst    (hburst),
    .hready    (hready),
    .hgrant    (hgrant),
    .dsel      (dsel),
    .hmaster   (hmaster),
    .hmastlock (hmastlock)
  );

  function automatic logic [2:0] oh2idx(input logic [7:0] oh);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) r = 3'(i);
    end
    return r;
  endfunction

  // Drives one cycle of inputs; eg/ed/el are the outputs expected during this cycle.
  task automatic cyc(input string tag, input logic rst, input logic [7:0] rq, input logic [7:0] lk,
                     input logic [1:0] tr, input logic [2:0] hb, input logic rdy,
                     input logic [7:0] eg, input logic [7:0] ed, input logic el);
    exp_t e;
    hrst   = rst;
    mreq   = rq;
    mlock  = lk;
    htrans = tr;
    hburst = hb;
    hready = rdy;
    e.g   = eg;
    e.d   = ed;
    e.m   = oh2idx(eg);
    e.l   = el;
    e.tag = tag;
    sb_q.push_back(e);
    @(posedge hclk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge hclk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        tests_run++;
        if (hgrant !== e.g || dsel !== e.d || hmaster !== e.m || hmastlock !== e.l) begin
          tests_failed++;
          $display("FAIL %s: got hgrant=%h dsel=%h hmaster=%0d hmastlock=%b, want hgrant=%h dsel=%h hmaster=%0d hmastlock=%b",
                   e.tag, hgrant, dsel, hmaster, hmastlock, e.g, e.d, e.m, e.l);
        end else begin
          $display("[TB] ok %s: hgrant=%h dsel=%h hmaster=%0d hmastlock=%b",
                   e.tag, hgrant, dsel, hmaster, hmastlock);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    hrst = 1'b1; mreq = '0; mlock = '0; htrans = IDLE; hburst = SINGLE; hready = 1'b1;
    repeat (3) @(posedge hclk);
    #1;
`ifdef AHB_ARB_FIXED_PRIO_EN
    cyc("reset",   0, 8'h00, 8'h00, IDLE, SINGLE, 1, 8'h01, 8'h01, 0);
    cyc("fp_m0a",  0, 8'h81, 8'h00, NSEQ, SINGLE, 1, 8'h01, 8'h01, 0);
    cyc("fp_m0b",  0, 8'h81, 8'h00, NSEQ, SINGLE, 1, 8'h01, 8'h01, 0);
    cyc("fp_m0c",  0, 8'h81, 8'h00, NSEQ, SINGLE, 1, 8'h01, 8'h01, 0);
    cyc("fp_drop", 0, 8'h80, 8'h00, NSEQ, SINGLE, 1, 8'h01, 8'h01, 0);
    cyc("fp_m7",   0, 8'h80, 8'h00, NSEQ, SINGLE, 1, 8'h80, 8'h01, 0);
    cyc("fp_m7b",  0, 8'h81, 8'h00, NSEQ, SINGLE, 1, 8'h80, 8'h80, 0);
    cyc("fp_back", 0, 8'h00, 8'h00, IDLE, SINGLE, 1, 8'h01, 8'h80, 0);
`else
    // reset / park
    cyc("reset",    0, 8'h00, 8'h00, IDLE, SINGLE, 1, 8'h01, 8'h01, 0);
    // round-robin between M1 and M2
    cyc("rr_1",     0, 8'h06, 8'h00, NSEQ, SINGLE, 1, 8'h01, 8'h01, 0);
    cyc("rr_2",     0, 8'h06, 8'h00, NSEQ, SINGLE, 1, 8'h02, 8'h01, 0);
    cyc("rr_3",     0, 8'h06, 8'h00, NSEQ, SINGLE, 1, 8'h04, 8'h02, 0);
    cyc("rr_4",     0, 8'h06, 8'h00, NSEQ, SINGLE, 1, 8'h02, 8'h04, 0);
    cyc("rr_5",     0, 8'h06, 8'h00, NSEQ, SINGLE, 1, 8'h04, 8'h02, 0);
    // M1 INCR4 with everyone requesting
    cyc("i4_b1",    0, 8'hFF, 8'h00, NSEQ, INCR4,  1, 8'h02, 8'h04, 0);
    cyc("i4_b2",    0, 8'hFF, 8'h00, SEQ,  INCR4,  1, 8'h02, 8'h02, 0);
    cyc("i4_b3",    0, 8'hFF, 8'h00, SEQ,  INCR4,  1, 8'h02, 8'h02, 0);
    cyc("i4_b4",    0, 8'hFF, 8'h00, SEQ,  INCR4,  1, 8'h02, 8'h02, 0);
    // M2 INCR8 with two wait cycles mid-burst
    cyc("i8_b1",    0, 8'hFF, 8'h00, NSEQ, INCR8,  1, 8'h04, 8'h02, 0);
    cyc("i8_b2",    0, 8'hFF, 8'h00, SEQ,  INCR8,  1, 8'h04, 8'h04, 0);
    cyc("i8_b3",    0, 8'hFF, 8'h00, SEQ,  INCR8,  1, 8'h04, 8'h04, 0);
    cyc("i8_w1",    0, 8'hFF, 8'h00, SEQ,  INCR8,  0, 8'h04, 8'h04, 0);
    cyc("i8_w2",    0, 8'hFF, 8'h00, SEQ,  INCR8,  0, 8'h04, 8'h04, 0);
    cyc("i8_b4",    0, 8'hFF, 8'h00, SEQ,  INCR8,  1, 8'h04, 8'h04, 0);
    cyc("i8_b5",    0, 8'hFF, 8'h00, SEQ,  INCR8,  1, 8'h04, 8'h04, 0);
    cyc("i8_b6",    0, 8'hFF, 8'h00, SEQ,  INCR8,  1, 8'h04, 8'h04, 0);
    cyc("i8_b7",    0, 8'hFF, 8'h00, SEQ,  INCR8,  1, 8'h04, 8'h04, 0);
    cyc("i8_b8",    0, 8'hFF, 8'h00, SEQ,  INCR8,  1, 8'h04, 8'h04, 0);
    // hready low right after a grant change: dsel must not follow
    cyc("frz_1",    0, 8'hFF, 8'h00, IDLE, SINGLE, 0, 8'h08, 8'h04, 0);
    cyc("frz_2",    0, 8'hFF, 8'h00, IDLE, SINGLE, 0, 8'h08, 8'h04, 0);
    // M3 locked transfer
    cyc("lk_1",     0, 8'hFF, 8'h08, NSEQ, SINGLE, 1, 8'h08, 8'h04, 1);
    cyc("lk_2",     0, 8'hFF, 8'h08, NSEQ, SINGLE, 1, 8'h08, 8'h08, 1);
    cyc("lk_seq",   0, 8'hFF, 8'h00, SEQ,  SINGLE, 1, 8'h08, 8'h08, 0);
    cyc("lk_exit",  0, 8'hFF, 8'h00, IDLE, SINGLE, 1, 8'h08, 8'h08, 0);
    // M4 INCR4 terminated early by IDLE
    cyc("et_b1",    0, 8'hFF, 8'h00, NSEQ, INCR4,  1, 8'h10, 8'h08, 0);
    cyc("et_b2",    0, 8'hFF, 8'h00, SEQ,  INCR4,  1, 8'h10, 8'h10, 0);
    cyc("et_idle",  0, 8'hFF, 8'h00, IDLE, INCR4,  1, 8'h10, 8'h10, 0);
    // M5 WRAP16 interrupted by reset
    cyc("rb_b1",    0, 8'hFF, 8'h00, NSEQ, WRAP16, 1, 8'h20, 8'h10, 0);
    cyc("rb_b2",    0, 8'hFF, 8'h00, SEQ,  WRAP16, 1, 8'h20, 8'h20, 0);
    cyc("rb_rst",   1, 8'hFF, 8'h00, SEQ,  WRAP16, 1, 8'h20, 8'h20, 0);
    cyc("rb_after", 0, 8'h00, 8'h00, IDLE, SINGLE, 1, 8'h01, 8'h01, 0);
    // sole requester is the owner: regranted
    cyc("own_1",    0, 8'h01, 8'h00, NSEQ, SINGLE, 1, 8'h01, 8'h01, 0);
    cyc("own_2",    0, 8'h20, 8'h00, NSEQ, SINGLE, 1, 8'h01, 8'h01, 0);
    // idle bus parks back on the default master
    cyc("park_1",   0, 8'h00, 8'h00, IDLE, SINGLE, 1, 8'h20, 8'h01, 0);
    cyc("park_2",   0, 8'h00, 8'h00, IDLE, SINGLE, 1, 8'h01, 8'h20, 0);
`endif
    @(negedge hclk);
    #1;
    if (sb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: %0d expected entries left, want 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
